spi_tx_frame_arbiter: RTL
=========================

# spi_tx_frame_arbiter

Frame-level transmit scheduler for the 18-bit SPI slave path, running in the SPI clock domain. It shares the slave's MISO word slot between up to eight on-chip requesters, arbitrating round-robin at each frame boundary. The chosen word is presented to the slave's TX register one full frame before it is shifted out. It also produces per-requester capture and completion pulses and frame bookkeeping.

## Interface
- BIT_PER_TRANSFER, 18, bits per SPI frame; legal range 2..32
- NUM_REQ, 4, number of requesters; legal range 2..8
- IDLE_WORD, 18'h3FFFF, word sent when no requester is granted
- w_SPI_Clk  in  1  clock; leading-edge (sample) clock of the SPI link, toggles only while the master clocks
- i_Rst_L  in  1  reset i_Rst_L, asynchronous, active-low; clock w_SPI_Clk
- i_SPI_CS_n  in  1  chip select, sampled synchronously on w_SPI_Clk
- i_Req  in  NUM_REQ  request per requester, level; held until o_Ack
- i_Req_Data  in  NUM_REQ*BIT_PER_TRANSFER  word per requester; requester r uses slice [r*B +: B]
- o_TX_Word  out  BIT_PER_TRANSFER  word for the next frame, feeds slave TX register
- o_TX_Load  out  1  one-cycle pulse: o_TX_Word updated
- o_Grant  out  NUM_REQ  one-hot owner of o_TX_Word; all-zero means idle word
- o_Ack  out  NUM_REQ  one-cycle pulse: requester's word captured; requester may advance data
- o_Done  out  NUM_REQ  one-cycle pulse: owner's word fully shifted out
- o_Bit_Count  out  $clog2(BIT_PER_TRANSFER)  bit index within current frame
- o_Frame_Count  out  8  frames completed in current transaction, saturating at 255

## Operation
- Reset values: o_TX_Word = IDLE_WORD, all pulses, o_Grant, o_Bit_Count and o_Frame_Count = 0, RR pointer = NUM_REQ-1.
- States:
  - IDLE: entered on reset, or at any edge where i_SPI_CS_n = 1.
  - SHIFT: entered at the first edge where i_SPI_CS_n = 0.
- Edges with i_SPI_CS_n = 0:
  - o_Bit_Count increments and wraps from B-1 to 0.
  - The edge where o_Bit_Count == B-1 is the frame boundary.
- Frame boundary actions, all registered on the same edge:
  - o_Done pulses on the bit of the current o_Grant, if non-zero.
  - o_Frame_Count increments, saturating at 255.
  - Arbitration: search i_Req starting at pointer+1, modulo NUM_REQ. The first set bit wins.
  - Winner found: o_Grant = winner, o_TX_Word = winner's slice, o_Ack[winner] pulses, pointer = winner.
  - No winner: o_Grant = 0, o_TX_Word = IDLE_WORD, pointer unchanged.
  - o_TX_Load pulses in both cases.
- A requester acked at one boundary is eligible again at the next boundary; its data must have advanced after o_Ack.
- CS abort, i.e. any edge with i_SPI_CS_n = 1, including mid-frame:
  - o_Bit_Count and o_Frame_Count clear.
  - No o_Done is issued.
  - o_Grant and o_TX_Word are retained. The pending word is sent as frame 0 of the next transaction, and o_Done fires when that frame completes.
- After reset, frame 0 of the first transaction carries IDLE_WORD with o_Grant = 0.
- Requests that change between boundaries are ignored; only the value at the boundary edge counts.

## Timing
- Arbitration latency: request to capture is at most one frame (B edges) plus the wait for the round-robin turn. Worst-case wait is NUM_REQ frames.
- o_TX_Word is stable for the whole frame that shifts it out. It changes only on the last bit's edge of the previous frame.
- o_Ack, o_Done and o_TX_Load are each exactly one w_SPI_Clk cycle wide.
- At a boundary, o_Done for the old owner and o_Ack/o_Grant for the new owner are simultaneous. They may be the same requester.
- Asynchronous reset mid-frame returns all outputs to their reset values immediately. A pending word is dropped without o_Done.
- i_Req and i_Req_Data come from the i_Clk domain and must be stable for at least one w_SPI_Clk period before the boundary edge.

## Configuration
- SPI_TX_ARB_IDLE_REPEAT_EN defined: with no winner, o_TX_Word keeps its previous value (last word repeated), o_Grant = 0, o_TX_Load still pulses.
- SPI_TX_ARB_IDLE_REPEAT_EN undefined: with no winner, o_TX_Word = IDLE_WORD.

## Test plan
- Reset, CS low, 2 frames, no requests -> both frames carry 18'h3FFFF; o_Grant = 0; o_Frame_Count = 2; no o_Ack or o_Done.
- i_Req = 4'b1111 held with distinct data, 5 frames -> grants in order 0,1,2,3,0; o_Ack on the boundary edge each time; each o_Done one frame later.
- Only req 2 active with data 18'h2A5A5 -> o_Ack[2] at end of frame 0; frame 1 shifts 18'h2A5A5; o_Done[2] at end of frame 1.
- Abort at bit 7 of a granted frame, then new transaction -> no o_Done at abort; o_Bit_Count = 0; frame 0 of the new transaction resends the word; o_Done fires at its end.
- i_Rst_L low mid-frame -> all outputs at reset values within the same cycle; pointer restarts so req 0 wins first.
- With the macro defined, req 1 sends 18'h00123 then drops -> next frame repeats 18'h00123 with o_Grant = 0. Without the macro -> next frame is 18'h3FFFF.

Source files
------------

// File: rtl/spi_tx_frame_arbiter.sv
// spi_tx_frame_arbiter
// Frame-level MISO word scheduler for the SPI slave path, clocked by the SPI
// sample clock. Up to NUM_REQ requesters share the slave's TX word slot. A
// round-robin winner is chosen at every frame boundary, and its word is handed
// to the slave TX register one full frame before that word is shifted out.
// Per-requester capture (o_Ack) and completion (o_Done) pulses are produced,
// together with bit and frame bookkeeping.
//
// Optional feature macro: SPI_TX_ARB_IDLE_REPEAT_EN
//   defined   : a boundary with no winner repeats the previous TX word
//   undefined : a boundary with no winner loads IDLE_WORD
module spi_tx_frame_arbiter #(
  parameter int                          BIT_PER_TRANSFER = 18,
  parameter int                          NUM_REQ          = 4,
  parameter logic [BIT_PER_TRANSFER-1:0] IDLE_WORD        = BIT_PER_TRANSFER'(18'h3FFFF)
) (
  input  logic                                w_SPI_Clk,
  input  logic                                i_Rst_L,
  input  logic                                i_SPI_CS_n,
  input  logic [NUM_REQ-1:0]                  i_Req,
  input  logic [NUM_REQ*BIT_PER_TRANSFER-1:0] i_Req_Data,
  output logic [BIT_PER_TRANSFER-1:0]         o_TX_Word,
  output logic                                o_TX_Load,
  output logic [NUM_REQ-1:0]                  o_Grant,
  output logic [NUM_REQ-1:0]                  o_Ack,
  output logic [NUM_REQ-1:0]                  o_Done,
  output logic [$clog2(BIT_PER_TRANSFER)-1:0] o_Bit_Count,
  output logic [7:0]                          o_Frame_Count
);

  localparam int CNT_W = $clog2(BIT_PER_TRANSFER);
  localparam int PTR_W = $clog2(NUM_REQ);

  localparam logic [CNT_W-1:0]   LAST_BIT  = CNT_W'(BIT_PER_TRANSFER - 1);
  localparam logic [PTR_W-1:0]   PTR_RESET = PTR_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0  = NUM_REQ'(1);

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_t;

  // Registered state
  state_t                      r_state;
  logic [CNT_W-1:0]            r_bit_count;
  logic [7:0]                  r_frame_count;
  logic [PTR_W-1:0]            r_ptr;
  logic [NUM_REQ-1:0]          r_grant;
  logic [BIT_PER_TRANSFER-1:0] r_tx_word;
  logic                        r_tx_load;
  logic [NUM_REQ-1:0]          r_ack;
  logic [NUM_REQ-1:0]          r_done;

  // Next-state values
  state_t                      w_state_nxt;
  logic [CNT_W-1:0]            w_bit_count_nxt;
  logic [7:0]                  w_frame_count_nxt;
  logic [PTR_W-1:0]            w_ptr_nxt;
  logic [NUM_REQ-1:0]          w_grant_nxt;
  logic [BIT_PER_TRANSFER-1:0] w_tx_word_nxt;
  logic                        w_tx_load_nxt;
  logic [NUM_REQ-1:0]          w_ack_nxt;
  logic [NUM_REQ-1:0]          w_done_nxt;

  // Arbitration results
  logic [BIT_PER_TRANSFER-1:0] w_req_words [NUM_REQ];
  logic                        w_win_found;
  logic [PTR_W-1:0]            w_win_idx;
  logic [PTR_W-1:0]            w_cand;
  logic [NUM_REQ-1:0]          w_win_onehot;
  logic [BIT_PER_TRANSFER-1:0] w_win_word;
  logic [CNT_W-1:0]            w_bit_cur;

  // Split the flat data bus into one word per requester
  always_comb begin
    for (int r = 0; r < NUM_REQ; r++) begin
      w_req_words[r] = i_Req_Data[r*BIT_PER_TRANSFER +: BIT_PER_TRANSFER];
    end
  end

  // Round-robin search of i_Req starting just after the last winner
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no
    // path can leave a value unassigned and infer a latch.
    w_win_found = 1'b0;
    w_win_idx   = '0;
    w_cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = PTR_W'((int'(r_ptr) + k) % NUM_REQ);
      if (!w_win_found && i_Req[w_cand]) begin
        w_win_found = 1'b1;
        w_win_idx   = w_cand;
      end
    end
    w_win_onehot = ONE_HOT0 << w_win_idx;
    w_win_word   = w_req_words[w_win_idx];
  end

  // Next-state logic: bit counting, boundary actions and CS abort
  always_comb begin
    w_state_nxt       = r_state;
    w_bit_count_nxt   = r_bit_count;
    w_frame_count_nxt = r_frame_count;
    w_ptr_nxt         = r_ptr;
    w_grant_nxt       = r_grant;
    w_tx_word_nxt     = r_tx_word;
    w_tx_load_nxt     = 1'b0;
    w_ack_nxt         = '0;
    w_done_nxt        = '0;
    w_bit_cur         = (r_state == ST_SHIFT) ? r_bit_count : '0;

    if (i_SPI_CS_n) begin
      // Abort or idle: counters restart, the pending word and owner are kept
      // so the word goes out as frame 0 of the next transaction.
      w_state_nxt       = ST_IDLE;
      w_bit_count_nxt   = '0;
      w_frame_count_nxt = '0;
    end else begin
      w_state_nxt = ST_SHIFT;
      if (w_bit_cur == LAST_BIT) begin
        // Frame boundary: retire the old owner, pick and load the next word
        w_bit_count_nxt   = '0;
        w_done_nxt        = r_grant;
        w_frame_count_nxt = (r_frame_count == 8'hFF) ? 8'hFF : r_frame_count + 8'd1;
        w_tx_load_nxt     = 1'b1;
        if (w_win_found) begin
          w_grant_nxt   = w_win_onehot;
          w_ack_nxt     = w_win_onehot;
          w_tx_word_nxt = w_win_word;
          w_ptr_nxt     = w_win_idx;
        end else begin
          w_grant_nxt = '0;
`ifdef SPI_TX_ARB_IDLE_REPEAT_EN
          w_tx_word_nxt = r_tx_word;
`else
          w_tx_word_nxt = IDLE_WORD;
`endif
        end
      end else begin
        w_bit_count_nxt = w_bit_cur + 1'b1;
      end
    end
  end

  // State register with asynchronous active-low reset
  always_ff @(posedge w_SPI_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state       <= ST_IDLE;
      r_bit_count   <= '0;
      r_frame_count <= '0;
      r_ptr         <= PTR_RESET;
      r_grant       <= '0;
      r_tx_word     <= IDLE_WORD;
      r_tx_load     <= 1'b0;
      r_ack         <= '0;
      r_done        <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      r_state       <= w_state_nxt;
      r_bit_count   <= w_bit_count_nxt;
      r_frame_count <= w_frame_count_nxt;
      r_ptr         <= w_ptr_nxt;
      r_grant       <= w_grant_nxt;
      r_tx_word     <= w_tx_word_nxt;
      r_tx_load     <= w_tx_load_nxt;
      r_ack         <= w_ack_nxt;
      r_done        <= w_done_nxt;
    end
  end

  assign o_TX_Word     = r_tx_word;
  assign o_TX_Load     = r_tx_load;
  assign o_Grant       = r_grant;
  assign o_Ack         = r_ack;
  assign o_Done        = r_done;
  assign o_Bit_Count   = r_bit_count;
  assign o_Frame_Count = r_frame_count;

endmodule
